// File: rtl/blur_out_packer.sv
// Packs the blurred 8-bit pixel stream into 32-bit words tagged with sof/eol/eof and
// buffers them in a show-ahead FIFO. Optional statistics counters: `define BLUR_PACK_STATS_EN.
module blur_out_packer #(
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 24,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  pix_in,
   input  logic        pix_vld,
   output logic [31:0] m_data,
   output logic        m_sof,
   output logic        m_eol,
   output logic        m_eof,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        ovf_err,
   input  logic        clr_err,
   output logic        frame_done
`ifdef BLUR_PACK_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
`endif
);

   localparam int WPL = IMG_W / 4;
   localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
   localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int EW  = 35;  // {sof, eol, eof, data[31:0]}

   logic [1:0]    lane_q, lane_d;
   logic [23:0]   pack_q, pack_d;
   logic [CW-1:0] word_col_q, word_col_d;
   logic [RW-1:0] row_q, row_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic          ovf_q, ovf_d;
   logic          frame_done_q, frame_done_d;

   logic          push_req, push_ok, pop, drop, empty, full;
   logic          sof, eol, eof;
   logic [EW-1:0] head;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign push_req = pix_vld && (lane_q == 2'd3);
   assign pop      = !empty && m_ready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push_ok  = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   assign sof = (word_col_q == '0) && (row_q == '0);
   assign eol = (word_col_q == CW'(WPL - 1));
   assign eof = eol && (row_q == RW'(IMG_H - 1));

   always_comb begin
      lane_d     = lane_q;
      pack_d     = pack_q;
      word_col_d = word_col_q;
      row_d      = row_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_d      = mem_q;
      if (pix_vld) begin
         lane_d = lane_q + 2'd1;
         case (lane_q)
            2'd0:    pack_d[7:0]   = pix_in;
            2'd1:    pack_d[15:8]  = pix_in;
            2'd2:    pack_d[23:16] = pix_in;
            default: pack_d        = pack_q;
         endcase
      end
      // Position advances on every completed word, dropped or not, to keep alignment.
      if (push_req) begin
         if (eol) begin
            word_col_d = '0;
            row_d      = eof ? '0 : row_q + RW'(1);
         end else begin
            word_col_d = word_col_q + CW'(1);
         end
      end
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = {sof, eol, eof, pix_in, pack_q};
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      ovf_d        = drop | (ovf_q & ~clr_err);
      frame_done_d = pop && head[32];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q       <= '0;
         pack_q       <= '0;
         word_col_q   <= '0;
         row_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ovf_q        <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         lane_q       <= lane_d;
         pack_q       <= pack_d;
         word_col_q   <= word_col_d;
         row_q        <= row_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ovf_q        <= ovf_d;
         frame_done_q <= frame_done_d;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Head fields read as zero whenever nothing is queued.
   assign m_valid    = !empty;
   assign m_data     = empty ? 32'd0 : head[31:0];
   assign m_sof      = !empty && head[34];
   assign m_eol      = !empty && head[33];
   assign m_eof      = !empty && head[32];
   assign ovf_err    = ovf_q;
   assign frame_done = frame_done_q;

`ifdef BLUR_PACK_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q + 16'(frame_done_q);
      if (clr_err)
         drop_cnt_d = 16'(drop);
      else if (drop && drop_cnt_q != 16'hFFFF)
         drop_cnt_d = drop_cnt_q + 16'd1;
      else
         drop_cnt_d = drop_cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule
